imm_gen_rv64: RTL and testbench

RV64I immediate generator for the decode stage. Takes a 32-bit instruction word, classifies it by opcode into I/S/B/U/J format, and produces the sign-extended 64-bit immediate plus a format tag. Output is registered, one cycle after the input. Its consumers are the ALU operand mux, AGU and branch/jump target adders.

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_decode.sv | 53 +++++
 rtl/imm_gen_rv64.sv | 38 +++
 tb/tb_imm_gen_rv64.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for RV64I immediate decoding.
package imm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned FMT_W   = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> sign-extended immediate and format tag.
// Shared with the branch predictor for early target computation.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    imm_c,
    output imm_fmt_t           imm_fmt_c
);

    logic             sign;
    logic [OPC_W-1:0] opcode;

    assign sign   = instruction[31];
    assign opcode = instruction[OPC_W-1:0];

    // Every format replicates instruction[31] into the upper bits.
    always_comb begin
        imm_c     = '0;
        imm_fmt_c = FMT_NONE;
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM: begin
                imm_c     = {{(XLEN-12){sign}}, instruction[31:20]};
                imm_fmt_c = FMT_I;
            end
            OPC_STORE: begin
                imm_c     = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
                imm_fmt_c = FMT_S;
            end
            OPC_BRANCH: begin
                imm_c     = {{(XLEN-13){sign}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
                imm_fmt_c = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_c     = {{(XLEN-32){sign}}, instruction[31:12], 12'b0};
                imm_fmt_c = FMT_U;
            end
            OPC_JAL: begin
                imm_c     = {{(XLEN-21){sign}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
                imm_fmt_c = FMT_J;
            end
            default: begin
                imm_c     = '0;
                imm_fmt_c = FMT_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_rv64.sv
// Decode-stage immediate generator: combinational decode plus one output register stage.
module imm_gen_rv64
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    output logic [XLEN-1:0]    imm,
    output imm_fmt_t           imm_fmt
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .imm_c       (dec_imm),
        .imm_fmt_c   (dec_fmt)
    );

    // Data loads every cycle regardless of in_valid; out_valid alone qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            imm       <= '0;
            imm_fmt   <= FMT_NONE;
        end else begin
            out_valid <= in_valid;
            imm       <= dec_imm;
            imm_fmt   <= dec_fmt;
        end
    end

endmodule

// File: tb/tb_imm_gen_rv64.sv
// Self-checking bench for imm_gen_rv64: directed vectors plus a random stream against a reference model.
module tb_imm_gen_rv64;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [63:0] imm;
    logic [2:0]  imm_fmt;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic        v;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    imm_gen_rv64 #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .imm         (imm),
        .imm_fmt     (imm_fmt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model built with arithmetic shifts rather than bit concatenation.
    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: return 3'd1;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] w;
        logic [31:0] r;
        w = ins;
        case (ref_fmt(ins))
            3'd1: r = 32'(w >>> 20);
            3'd2: r = (32'(w >>> 20) & ~32'h1F) | {27'b0, ins[11:7]};
            3'd3: r = (32'(w >>> 19) & 32'hFFFFF000) |
                      {20'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4: r = ins & 32'hFFFFF000;
            3'd5: r = (32'(w >>> 11) & 32'hFFF00000) |
                      {12'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: r = 32'h0;
        endcase
        return {{32{r[31]}}, r};
    endfunction

    task automatic send(input string tag, input logic [31:0] ins, input logic v,
                        input logic [63:0] e_imm, input logic [2:0] e_fmt);
        exp_t e;
        @(negedge clk);
        instruction = ins;
        in_valid    = v;
        e.tag = tag;
        e.v   = v;
        e.imm = e_imm;
        e.fmt = e_fmt;
        sb.push_back(e);
    endtask

    // Each pushed expectation is due just after the next rising edge.
    always @(posedge clk) begin
        if (rst_n && sb.size() != 0) begin
            #1;
            mon_e = sb.pop_front();
            check({mon_e.tag, ".valid"}, 64'(out_valid), 64'(mon_e.v));
            check({mon_e.tag, ".imm"},   imm,            mon_e.imm);
            check({mon_e.tag, ".fmt"},   64'(imm_fmt),   64'(mon_e.fmt));
        end
    end

    localparam logic [6:0] OPCS [11] = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73,
                                         7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] r;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        #1;
        check("por.valid", 64'(out_valid), 64'h0);
        check("por.imm",   imm,            64'h0);
        check("por.fmt",   64'(imm_fmt),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-cycle after a valid result has been registered.
        send("pre_rst", 32'hFFF00093, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst.valid", 64'(out_valid), 64'h0);
        check("rst.imm",   imm,            64'h0);
        check("rst.fmt",   64'(imm_fmt),   64'h0);
        @(posedge clk);
        #1;
        check("rst_hold.valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, driven back-to-back.
        send("addi",  32'hFFF00093, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        send("sd",    32'h0020B423, 1'b1, 64'h0000000000000008, 3'd2);
        send("beq",   32'hFE000EE3, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd3);
        send("lui",   32'h800000B7, 1'b1, 64'hFFFFFFFF80000000, 3'd4);
        send("jal",   32'h001000EF, 1'b1, 64'h0000000000000800, 3'd5);
        send("zero",  32'h00000000, 1'b1, 64'h0, 3'd0);
        send("ones",  32'hFFFFFFFF, 1'b1, 64'h0, 3'd0);
        send("fff",   32'h00000FFF, 1'b1, 64'h0, 3'd0);
        send("inv",   32'hFFF00093, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        send("auipc", 32'h12345017, 1'b1, 64'h0000000012345000, 3'd4);
        send("jneg",  32'hFFDFF06F, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd5);
        send("sneg",  32'hFE112E23, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd2);

        // Random stream, mostly valid opcodes with random other bits.
        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0)
                r[6:0] = OPCS[$urandom_range(0, 10)];
            send("rand", r, 1'($urandom_range(0, 1)), ref_imm(r), ref_fmt(r));
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
